snake_palette_axil: RTL and testbench
=====================================

SNAKE_PALETTE_AXIL -- requirements
Module: snake_palette_axil

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 32, meaning AXI4-Lite data width; legal values are 32 or 64.
REQ-002 The block SHALL have parameter C_NUM_REGS, default 16, meaning register count; legal range is 2..256.
REQ-003 The block SHALL have parameter C_ADDR_WIDTH, default 6, meaning byte-address width; it SHALL be at least clog2(C_NUM_REGS)+clog2(C_DATA_WIDTH/8).
REQ-004 The block SHALL have parameter C_RO_MASK, default 0 (C_NUM_REGS bits); a set bit i makes register i read-only.
REQ-005 ACLK  in  1  single clock; all logic on rising edge.
REQ-006 ARESET  in  1  reset; synchronous and active-high.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID  in  C_ADDR_WIDTH/3/1, and S_AXI_AWREADY  out  1: write address channel; AWPROT is ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID  in  C_DATA_WIDTH/C_DATA_WIDTH/8/1, and S_AXI_WREADY  out  1: write data channel.
REQ-009 S_AXI_BRESP/BVALID  out  2/1, and S_AXI_BREADY  in  1: write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID  in  C_ADDR_WIDTH/3/1, and S_AXI_ARREADY  out  1: read address channel; ARPROT is ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID  out  C_DATA_WIDTH/2/1, and S_AXI_RREADY  in  1: read data channel.
REQ-012 ro_data_i  in  C_NUM_REGS*C_DATA_WIDTH  live status values returned for read-only registers.
REQ-013 regs_o  out  C_NUM_REGS*C_DATA_WIDTH  flattened read/write register contents; register i occupies slice i.
REQ-014 reg_wr_o  out  C_NUM_REGS  one-cycle pulse per register on each successful write.

Function
REQ-015 Register index SHALL be the byte address shifted right by clog2(C_DATA_WIDTH/8); the low byte-offset bits SHALL be ignored.
REQ-016 The write FSM SHALL have states W_IDLE, W_ACK and W_RESP.
REQ-017 The write FSM SHALL go W_IDLE->W_ACK when AWVALID and WVALID are both high; a lone AWVALID or lone WVALID SHALL wait with no ready asserted.
REQ-018 In W_ACK, AWREADY and WREADY SHALL be high together for exactly one cycle while address, data and strobe are captured; the FSM SHALL then go to W_RESP.
REQ-019 On the W_ACK->W_RESP edge, a writable, in-range register SHALL update only the byte lanes whose WSTRB bit is set, and its reg_wr_o bit SHALL pulse for the following cycle.
REQ-020 BVALID SHALL assert on entry to W_RESP, with regs_o already updated, and SHALL hold with stable BRESP until BREADY is high; the FSM SHALL then return to W_IDLE.
REQ-021 A write to a read-only or out-of-range index SHALL change no register, SHALL not pulse reg_wr_o, and SHALL return BRESP=2'b10 (SLVERR); otherwise BRESP SHALL be 2'b00.
REQ-022 A write with WSTRB=0 SHALL leave data unchanged, SHALL still pulse reg_wr_o, and SHALL return OKAY.
REQ-023 The read FSM SHALL have states R_IDLE, R_ACK and R_DATA, and SHALL run independently of the write FSM.
REQ-024 The read FSM SHALL go R_IDLE->R_ACK on ARVALID; ARREADY SHALL be high for exactly the one R_ACK cycle, and the FSM SHALL then go to R_DATA.
REQ-025 RDATA SHALL be registered on the R_ACK->R_DATA edge: a read/write register returns its stored value, a read-only register returns its ro_data_i slice sampled on that edge, and an out-of-range index returns 0 with RRESP=2'b10.
REQ-026 RVALID SHALL hold with stable RDATA/RRESP until RREADY is high; the FSM SHALL then return to R_IDLE.
REQ-027 If a write commits on the same edge that read data is sampled, the read SHALL return the pre-write value.
REQ-028 Minimum latency SHALL be 2 cycles from AW/W valid to BVALID and 2 cycles from ARVALID to RVALID; maximum throughput is one write per 3 cycles and one read per 3 cycles.

Reset
REQ-029 While ARESET is high, all READY/VALID outputs SHALL be 0, BRESP/RRESP/RDATA SHALL be 0, regs_o SHALL be 0, reg_wr_o SHALL be 0, and both FSMs SHALL be IDLE.
REQ-030 A reset asserted mid-transaction SHALL abort it on the next edge: a pending BVALID or RVALID drops, and a write not yet committed is discarded.

Verification
REQ-031 Reset, then write 1..4 to byte addresses 0x0, 0x4, 0x8, 0xC and read them back -> BRESP=00, RDATA=1..4, RRESP=00, and each reg_wr_o bit pulses once.
REQ-032 Register 2 = 0xAABBCCDD; write 0x11223344 to register 2 with WSTRB=4'b0101 -> readback 0xAA22CC44.
REQ-033 C_RO_MASK bit 3 set, ro_data_i slice 3 = 0xDEADBEEF; write 0x5 to 0xC -> BRESP=10, no reg_wr_o[3] pulse; read 0xC -> 0xDEADBEEF, RRESP=00.
REQ-034 C_NUM_REGS=12; read 0x30 -> RDATA=0, RRESP=10; write 0x30 -> BRESP=10.
REQ-035 Hold BREADY/RREADY low for 10 cycles -> BVALID/RVALID and data stay stable; AWVALID driven without WVALID for 5 cycles -> AWREADY stays 0.
REQ-036 Assert ARESET while BVALID=1 with register 0 = 0x7 -> BVALID=0 and regs_o=0 next cycle, and a read of 0x0 after reset returns 0.

Source files
------------

// File: rtl/snake_palette_axil.sv
// snake_palette_axil: AXI4-Lite slave exposing a bank of C_NUM_REGS registers.
//
// Registers flagged in C_RO_MASK are read-only. Reads of those registers return the live
// ro_data_i slice, and writes to them are refused with SLVERR. The remaining registers are
// read/write, with byte-lane strobes honoured. Their contents are driven on regs_o, and
// reg_wr_o pulses for one cycle after each accepted write.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*     AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*        AXI4-Lite read address / data channels
//   ro_data_i           live status values for read-only registers (slice i = register i)
//   regs_o              flattened register contents (slice i = register i)
//   reg_wr_o            one-cycle write pulse per register
module snake_palette_axil #(
  parameter int unsigned              C_DATA_WIDTH = 32,
  parameter int unsigned              C_NUM_REGS   = 16,
  parameter int unsigned              C_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0]    C_RO_MASK    = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   ro_data_i,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   regs_o,
  output logic [C_NUM_REGS-1:0]                reg_wr_o
);

  localparam int unsigned StrbW   = C_DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

  // Protection bits carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // ---------------------------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------------------------
  wr_state_e wr_state_q, wr_state_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = W_ACK;
      W_ACK:  wr_state_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (wr_state_q == W_ACK);
    S_AXI_WREADY  = (wr_state_q == W_ACK);
    S_AXI_BVALID  = (wr_state_q == W_RESP);
  end

  // ---------------------------------------------------------------------------------------------
  // Write decode and register storage
  // ---------------------------------------------------------------------------------------------
  logic [C_ADDR_WIDTH-1:0] wr_idx;
  logic [C_NUM_REGS-1:0]   wr_sel;
  logic [C_NUM_REGS-1:0]   wr_ok_sel;
  logic                    wr_commit;

  assign wr_idx    = S_AXI_AWADDR >> AddrLsb;
  assign wr_commit = (wr_state_q == W_ACK);

  // Out-of-range indices match no entry, so they fall out as SLVERR naturally.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++) begin
      wr_sel[i] = (wr_idx == C_ADDR_WIDTH'(i));
    end
  end

  assign wr_ok_sel = wr_sel & ~C_RO_MASK;

  logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic [1:0]              bresp_q, bresp_d;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(C_NUM_REGS); i++) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wr_commit && wr_ok_sel[i] && S_AXI_WSTRB[b]) begin
          regs_d[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
      end
    end
    // A zero-strobe write still counts as a write for the pulse.
    reg_wr_d = wr_commit ? wr_ok_sel : '0;
    bresp_d  = bresp_q;
    if (wr_commit) begin
      bresp_d = (|wr_ok_sel) ? RespOkay : RespSlverr;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q   <= '{default: '0};
      reg_wr_q <= '0;
      bresp_q  <= RespOkay;
    end else begin
      regs_q   <= regs_d;
      reg_wr_q <= reg_wr_d;
      bresp_q  <= bresp_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++) begin
      regs_o[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[i];
    end
  end

  assign reg_wr_o    = reg_wr_q;
  assign S_AXI_BRESP = bresp_q;

  // ---------------------------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------------------------
  rd_state_e rd_state_q, rd_state_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE: if (S_AXI_ARVALID) rd_state_d = R_ACK;
      R_ACK:  rd_state_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (rd_state_q == R_ACK);
    S_AXI_RVALID  = (rd_state_q == R_DATA);
  end

  // ---------------------------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------------------------
  logic [C_ADDR_WIDTH-1:0] rd_idx;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  assign rd_idx = S_AXI_ARADDR >> AddrLsb;

  // regs_q is read before this edge's write lands, so a colliding read sees the old value.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_state_q == R_ACK) begin
      rdata_d = '0;
      rresp_d = RespSlverr;
      for (int i = 0; i < int'(C_NUM_REGS); i++) begin
        if (rd_idx == C_ADDR_WIDTH'(i)) begin
          rresp_d = RespOkay;
          rdata_d = C_RO_MASK[i] ? ro_data_i[i*C_DATA_WIDTH +: C_DATA_WIDTH] : regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_snake_palette_axil.sv
// Testbench for snake_palette_axil. Two instances are used: dut 0 has 16 writable registers,
// and dut 1 has 12 registers with registers 3 and 7 read-only. A register-bank model predicts
// register contents, write pulses and responses. It is checked every cycle and after each
// transaction.
module tb_snake_palette_axil;

  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] awaddr, araddr;
  logic [1:0]         awvalid, wvalid, bready, arvalid, rready;
  logic [1:0][DW-1:0] wdata;
  logic [1:0][3:0]    wstrb;
  logic [1:0]         awready, wready, bvalid, arready, rvalid;
  logic [1:0][1:0]    bresp, rresp;
  logic [1:0][DW-1:0] rdata;
  logic [16*DW-1:0]   ro_a, regs_a;
  logic [12*DW-1:0]   ro_b, regs_b;
  logic [15:0]        wr_a;
  logic [11:0]        wr_b;

  snake_palette_axil #(
    .C_DATA_WIDTH(32), .C_NUM_REGS(16), .C_ADDR_WIDTH(6), .C_RO_MASK(16'h0000)
  ) u_dut_a (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid[0]),
    .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]), .S_AXI_WVALID(wvalid[0]),
    .S_AXI_WREADY(wready[0]),
    .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready[0]),
    .S_AXI_ARADDR(araddr[0]), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid[0]),
    .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]),
    .S_AXI_RREADY(rready[0]),
    .ro_data_i(ro_a), .regs_o(regs_a), .reg_wr_o(wr_a)
  );

  snake_palette_axil #(
    .C_DATA_WIDTH(32), .C_NUM_REGS(12), .C_ADDR_WIDTH(6), .C_RO_MASK(12'h088)
  ) u_dut_b (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid[1]),
    .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]), .S_AXI_WVALID(wvalid[1]),
    .S_AXI_WREADY(wready[1]),
    .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready[1]),
    .S_AXI_ARADDR(araddr[1]), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid[1]),
    .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]),
    .S_AXI_RREADY(rready[1]),
    .ro_data_i(ro_b), .regs_o(regs_b), .reg_wr_o(wr_b)
  );

  // ----------------------------------------------------------------------------------------------
  // Model: a plain register bank per DUT
  // ----------------------------------------------------------------------------------------------
  int          nregs   [2] = '{16, 12};
  logic [15:0] ro_mask [2] = '{16'h0000, 16'h0088};
  logic [31:0] m_regs  [2][16];
  logic [15:0] exp_wr  [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d @%0t: got 0x%08h, expected 0x%08h", name, d, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int d, input int i);
    return (d == 0) ? regs_a[i*32 +: 32] : regs_b[i*32 +: 32];
  endfunction

  function automatic logic [31:0] ro_val(input int d, input int i);
    return (d == 0) ? ro_a[i*32 +: 32] : ro_b[i*32 +: 32];
  endfunction

  function automatic logic [15:0] dut_wr(input int d);
    return (d == 0) ? wr_a : {4'b0000, wr_b};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_wr[d] = '0;
      for (int i = 0; i < 16; i++) m_regs[d][i] = '0;
    end
  endtask

  task automatic randomize_ro();
    for (int i = 0; i < 16; i++) ro_a[i*32 +: 32] = $urandom;
    for (int i = 0; i < 12; i++) ro_b[i*32 +: 32] = $urandom;
  endtask

  // Every-cycle compare of writable register contents and write pulses.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int bad;
        int k;
        bad = -1;
        for (int i = 0; i < nregs[d]; i++) begin
          if (!ro_mask[d][i] && dut_reg(d, i) !== m_regs[d][i] && bad < 0) bad = i;
        end
        k = (bad < 0) ? 0 : bad;
        chk("regs_o", d, dut_reg(d, k), m_regs[d][k]);
        chk("reg_wr_o", d, {16'h0, dut_wr(d)}, {16'h0, exp_wr[d]});
      end
    end
  end

  // ----------------------------------------------------------------------------------------------
  // Transaction tasks
  // ----------------------------------------------------------------------------------------------
  task automatic wr_start(input int d, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int   idx;
    bit   ok;
    logic [1:0] want;
    idx  = int'(addr >> 2);
    ok   = (idx < nregs[d]) && !ro_mask[d][idx];
    want = ok ? 2'b00 : 2'b10;
    @(posedge clk); #1;
    awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    @(negedge clk);
    chk("awready_idle", d, 32'(awready[d]), 0);
    @(posedge clk);
    @(negedge clk);
    chk("awready_ack", d, 32'(awready[d]), 1);
    chk("wready_ack", d, 32'(wready[d]), 1);
    chk("bvalid_ack", d, 32'(bvalid[d]), 0);
    @(posedge clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    if (ok) begin
      m_regs[d][idx] = merge(m_regs[d][idx], data, strb);
      exp_wr[d] = 16'(1) << idx;
    end
    @(negedge clk);
    chk("bvalid", d, 32'(bvalid[d]), 1);
    chk("bresp", d, 32'(bresp[d]), 32'(want));
    chk("awready_resp", d, 32'(awready[d]), 0);
    resp = bresp[d];
    @(posedge clk); #1;
    exp_wr[d] = '0;
  endtask

  task automatic wr_finish(input int d, input int delay, input logic [1:0] resp);
    repeat (delay) begin
      @(negedge clk);
      chk("bvalid_hold", d, 32'(bvalid[d]), 1);
      chk("bresp_hold", d, 32'(bresp[d]), 32'(resp));
      @(posedge clk); #1;
    end
    bready[d] = 1'b1;
    @(negedge clk);
    chk("bvalid_hs", d, 32'(bvalid[d]), 1);
    @(posedge clk); #1;
    bready[d] = 1'b0;
    @(negedge clk);
    chk("bvalid_done", d, 32'(bvalid[d]), 0);
  endtask

  task automatic wr(input int d, input logic [AW-1:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int delay, output logic [1:0] resp);
    wr_start(d, addr, data, strb, resp);
    wr_finish(d, delay, resp);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] addr, input int delay,
                    output logic [31:0] data, output logic [1:0] resp);
    int   idx;
    logic [31:0] wd;
    logic [1:0]  wresp;
    idx = int'(addr >> 2);
    @(posedge clk); #1;
    if (idx >= nregs[d]) begin
      wd = '0; wresp = 2'b10;
    end else if (ro_mask[d][idx]) begin
      wd = ro_val(d, idx); wresp = 2'b00;
    end else begin
      wd = m_regs[d][idx]; wresp = 2'b00;
    end
    araddr[d] = addr; arvalid[d] = 1'b1;
    @(negedge clk);
    chk("arready_idle", d, 32'(arready[d]), 0);
    @(posedge clk);
    @(negedge clk);
    chk("arready_ack", d, 32'(arready[d]), 1);
    chk("rvalid_ack", d, 32'(rvalid[d]), 0);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    @(negedge clk);
    chk("rvalid", d, 32'(rvalid[d]), 1);
    chk("rdata", d, rdata[d], wd);
    chk("rresp", d, 32'(rresp[d]), 32'(wresp));
    chk("arready_data", d, 32'(arready[d]), 0);
    data = rdata[d];
    resp = rresp[d];
    repeat (delay) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid_hold", d, 32'(rvalid[d]), 1);
      chk("rdata_hold", d, rdata[d], wd);
      chk("rresp_hold", d, 32'(rresp[d]), 32'(wresp));
    end
    @(posedge clk); #1;
    rready[d] = 1'b1;
    @(negedge clk);
    chk("rvalid_hs", d, 32'(rvalid[d]), 1);
    @(posedge clk); #1;
    rready[d] = 1'b0;
    @(negedge clk);
    chk("rvalid_done", d, 32'(rvalid[d]), 0);
  endtask

  // ----------------------------------------------------------------------------------------------
  // Stimulus
  // ----------------------------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  br, rs;
    logic [31:0] rv;

    areset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    randomize_ro();
    clear_model();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, {29'b0, awready[d], wready[d], arready[d]}, 0);
      chk("rst_valid", d, {30'b0, bvalid[d], rvalid[d]}, 0);
      chk("rst_resp", d, {28'b0, bresp[d], rresp[d]}, 0);
      chk("rst_rdata", d, rdata[d], 0);
      chk("rst_reg_wr", d, {16'h0, dut_wr(d)}, 0);
    end
    chk("rst_regs", 0, 32'(|regs_a), 0);
    chk("rst_regs", 1, 32'(|regs_b), 0);
    @(posedge clk); #1;
    areset = 1'b0;
    chk_en = 1'b1;

    // Basic write/readback of registers 0..3
    for (int i = 0; i < 4; i++) begin
      wr(0, AW'(i * 4), 32'(i + 1), 4'hF, 0, br);
      chk("basic_bresp", 0, 32'(br), 0);
    end
    for (int i = 0; i < 4; i++) begin
      rd(0, AW'(i * 4), 0, rv, rs);
      chk("basic_rdata", 0, rv, 32'(i + 1));
      chk("basic_rresp", 0, 32'(rs), 0);
    end

    // Byte strobes, and low byte-offset bits ignored
    wr(0, 6'h08, 32'hAABBCCDD, 4'hF, 0, br);
    wr(0, 6'h08, 32'h11223344, 4'b0101, 0, br);
    rd(0, 6'h08, 0, rv, rs);
    chk("strobe_rdata", 0, rv, 32'hAA22CC44);
    rd(0, 6'h0B, 0, rv, rs);
    chk("offset_rdata", 0, rv, 32'hAA22CC44);

    // Zero strobe: data unchanged, OKAY, pulse still expected by the model
    wr(0, 6'h08, 32'hFFFFFFFF, 4'h0, 0, br);
    chk("zstrb_bresp", 0, 32'(br), 0);
    rd(0, 6'h08, 0, rv, rs);
    chk("zstrb_rdata", 0, rv, 32'hAA22CC44);

    // Read-only register
    ro_b[3*32 +: 32] = 32'hDEADBEEF;
    wr(1, 6'h0C, 32'h5, 4'hF, 0, br);
    chk("ro_bresp", 1, 32'(br), 2);
    rd(1, 6'h0C, 0, rv, rs);
    chk("ro_rdata", 1, rv, 32'hDEADBEEF);
    chk("ro_rresp", 1, 32'(rs), 0);

    // Out-of-range index on the 12-register instance
    rd(1, 6'h30, 0, rv, rs);
    chk("oor_rdata", 1, rv, 0);
    chk("oor_rresp", 1, 32'(rs), 2);
    wr(1, 6'h30, 32'h1234, 4'hF, 0, br);
    chk("oor_bresp", 1, 32'(br), 2);

    // Backpressure on both response channels
    wr(1, 6'h04, 32'h0BADF00D, 4'hF, 10, br);
    rd(1, 6'h04, 10, rv, rs);
    chk("bp_rdata", 1, rv, 32'h0BADF00D);

    // Lone AWVALID gets no ready
    @(posedge clk); #1;
    awaddr[0] = 6'h00; awvalid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("lone_awready", 0, 32'(awready[0]), 0);
      chk("lone_wready", 0, 32'(wready[0]), 0);
    end
    @(posedge clk); #1;
    awvalid[0] = 1'b0;

    // Simultaneous write and read of the same register: read sees the old value
    fork
      wr(0, 6'h04, 32'hCAFEF00D, 4'hF, 0, br);
      rd(0, 6'h04, 0, rv, rs);
    join
    chk("collide_rdata", 0, rv, 32'h2);
    rd(0, 6'h04, 0, rv, rs);
    chk("collide_after", 0, rv, 32'hCAFEF00D);

    // Randomized traffic
    repeat (150) begin
      int          d, op, dly;
      logic [AW-1:0] a;
      logic [31:0] dat;
      logic [3:0]  st;
      randomize_ro();
      d   = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 2));
      dly = int'($urandom_range(0, 3));
      a   = AW'($urandom_range(0, 63));
      dat = $urandom;
      st  = 4'($urandom);
      if (op == 0) begin
        wr(d, a, dat, st, dly, br);
      end else if (op == 1) begin
        rd(d, a, dly, rv, rs);
      end else begin
        fork
          wr(d, a, dat, st, dly, br);
          rd(d, AW'($urandom_range(0, 63)), dly, rv, rs);
        join
      end
    end

    // Reset while BVALID is pending
    wr_start(0, 6'h00, 32'h7, 4'hF, br);
    chk("abort_pre_reg0", 0, regs_a[31:0], 32'h7);
    areset = 1'b1;
    @(posedge clk); #1;
    clear_model();
    @(negedge clk);
    chk("abort_bvalid", 0, 32'(bvalid[0]), 0);
    chk("abort_reg0", 0, regs_a[31:0], 0);
    @(posedge clk); #1;
    areset = 1'b0;
    rd(0, 6'h00, 0, rv, rs);
    chk("abort_rdata", 0, rv, 0);
    chk("abort_rresp", 0, 32'(rs), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
